// File: rtl/sim_run_controller.sv
// Run/verdict controller between the bench and the core: sequences core reset, counts RUN cycles, and latches a verdict.
// Latency: core_rst_n rises RST_CYCLES edges after rst falls; verdict flags appear the cycle after the exit edge.
// Backpressure: none; monitors core activity passively every cycle and never stalls the core.
module sim_run_controller #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int CW          = 32,
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 1000,
  parameter int STALL_LIMIT = 8,
  parameter logic [AW-1:0] TOHOST_ADDR = AW'(32'h0000_00FC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic          core_rst_n,
  output logic [CW-1:0] cycle_count,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic          timeout,
  output logic          halted,
  output logic [DW-1:0] fail_code
);

  localparam int HW = (RST_CYCLES  > 1) ? $clog2(RST_CYCLES + 1)  : 1;
  localparam int SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT + 1) : 1;
  // Compared in 64 bits so a counter narrower than MAX_CYCLES simply never matches.
  localparam logic [63:0] MAX_M1 = 64'(MAX_CYCLES) - 64'd1;

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] stall_cnt;
  logic [AW-1:0] prev_pc;

  logic hold_last;
  logic tohost_hit;
  logic wdog_hit;
  logic pc_same;
  logic stall_hit;

  assign hold_last  = (hold_cnt == HW'(RST_CYCLES - 1));
  assign tohost_hit = mem_we && (mem_addr == TOHOST_ADDR);
  assign wdog_hit   = (MAX_CYCLES != 0) && (64'(cycle_count) == MAX_M1);
  assign pc_same    = (pc == prev_pc);
  assign stall_hit  = (STALL_LIMIT != 0) && pc_same && (stall_cnt == SW'(STALL_LIMIT - 1));

  // State register; terminal states hold until rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HOLD;
    else     state <= state_nxt;
  end

  // Next state: tohost verdict beats watchdog, watchdog beats stall halt.
  always_comb begin
    state_nxt = state;
    case (state)
      S_HOLD: if (hold_last) state_nxt = S_RUN;
      S_RUN: begin
        if (tohost_hit)     state_nxt = (mem_wdata == DW'(1)) ? S_PASS : S_FAIL;
        else if (wdog_hit)  state_nxt = S_TIMEOUT;
        else if (stall_hit) state_nxt = S_HALT;
      end
      default: state_nxt = state;
    endcase
  end

  // Counters, PC history and fail code; only HOLD and RUN update anything, so terminal values freeze.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt    <= '0;
      stall_cnt   <= '0;
      prev_pc     <= '0;
      cycle_count <= '0;
      fail_code   <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_last) prev_pc <= pc;
        end
        S_RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
          prev_pc <= pc;
          if (!pc_same)             stall_cnt <= '0;
          else if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
          if (tohost_hit && (mem_wdata != DW'(1))) fail_code <= mem_wdata >> 1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the state register, so they are glitch-free and one cycle behind the exit edge.
  always_comb begin
    core_rst_n = (state != S_HOLD);
    pass       = (state == S_PASS);
    fail       = (state == S_FAIL);
    timeout    = (state == S_TIMEOUT);
    halted     = (state == S_HALT);
    done       = pass || fail || timeout || halted;
  end

endmodule

// File: tb/tb_sim_run_controller.sv
// Bench for sim_run_controller: directed and random episodes against an array-scan reference model.
// Latency: checks every cycle from reset through HOLD, RUN and the frozen terminal state.
// Backpressure: none; inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_sim_run_controller;

  localparam int N       = 60;
  localparam int RSTC    = 3;
  localparam int MAXC    = 50;
  localparam int STALL   = 8;
  localparam logic [31:0] TOHOST = 32'h0000_00FC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        core_rst_n;
  logic [31:0] cycle_count;
  logic        done, pass, fail, timeout, halted;
  logic [31:0] fail_code;
  logic [4:0]  flags;

  assign flags = {done, pass, fail, timeout, halted};

  always #5 clk = ~clk;

  sim_run_controller #(
    .DW(32), .AW(32), .CW(32), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC),
    .STALL_LIMIT(STALL), .TOHOST_ADDR(TOHOST)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_rst_n(core_rst_n), .cycle_count(cycle_count),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout), .halted(halted),
    .fail_code(fail_code)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Episode stimulus: pcv[0] is the pc seen on the last HOLD edge, pcv[j+1] the pc of RUN cycle j.
  logic [31:0] pcv   [0:N];
  logic        wev   [0:N-1];
  logic [31:0] addrv [0:N-1];
  logic [31:0] datav [0:N-1];

  task automatic build(input int mode);
    int p;
    for (int i = 0; i <= N; i++) pcv[i] = 32'((i % 2) * 4);
    for (int j = 0; j < N; j++) begin
      wev[j] = 1'b0; addrv[j] = '0; datav[j] = '0;
    end
    case (mode)
      0: begin
        wev[5]  = 1'b1; addrv[5]  = 32'h100; datav[5]  = 32'd1;
        wev[10] = 1'b1; addrv[10] = TOHOST;  datav[10] = 32'd1;
      end
      1: begin
        p = $urandom_range(5, 40);
        wev[p]   = 1'b1; addrv[p]   = TOHOST; datav[p]   = 32'h0000_000B;
        wev[p+3] = 1'b1; addrv[p+3] = TOHOST; datav[p+3] = 32'd1;
      end
      2: ;
      3: begin
        wev[MAXC-1] = 1'b1; addrv[MAXC-1] = TOHOST; datav[MAXC-1] = 32'd1;
      end
      4: for (int i = 0; i <= N; i++) pcv[i] = (i <= 16) ? 32'(4 * i) : 32'h40;
      5: for (int i = 0; i <= N; i++) pcv[i] = 32'(4 * (i / 8));
      default: begin
        p = $urandom_range(2, 10);
        pcv[0] = 32'($urandom_range(0, 2) * 4);
        for (int i = 1; i <= N; i++)
          pcv[i] = ($urandom_range(0, p - 1) != 0) ? pcv[i-1] : 32'($urandom_range(0, 2) * 4);
        for (int j = 0; j < N; j++) begin
          wev[j]   = ($urandom_range(0, 11) == 0);
          addrv[j] = ($urandom_range(0, 2) == 0) ? 32'h100 : TOHOST;
          case ($urandom_range(0, 2))
            0:       datav[j] = 32'd1;
            1:       datav[j] = 32'd0;
            default: datav[j] = $urandom;
          endcase
        end
      end
    endcase
  endtask

  // Reference: first RUN cycle k whose rules fire; verdict 1 pass, 2 fail, 3 timeout, 4 halt.
  task automatic model(output int k, output int v, output logic [31:0] code);
    bit same;
    k = N; v = 0; code = '0;
    for (int j = 0; j < N; j++) begin
      if (wev[j] && addrv[j] == TOHOST) begin
        v = (datav[j] == 32'd1) ? 1 : 2;
        if (v == 2) code = datav[j] >> 1;
        k = j;
        break;
      end
      if (j == MAXC - 1) begin
        v = 3; k = j;
        break;
      end
      if (j >= STALL - 1) begin
        same = 1'b1;
        for (int i = j - STALL + 1; i <= j; i++) if (pcv[i] != pcv[j+1]) same = 1'b0;
        if (same) begin
          v = 4; k = j;
          break;
        end
      end
    end
  endtask

  task automatic run_episode(input int mode, input int abort_at);
    int k, v;
    logic [31:0] code;
    logic [4:0]  ef;
    build(mode);
    model(k, v, code);
    ef = (v == 0) ? 5'b0 : {1'b1, v == 1, v == 2, v == 3, v == 4};

    // tohost store held during reset and HOLD must be ignored
    pc = pcv[0]; mem_we = 1'b1; mem_addr = TOHOST; mem_wdata = 32'd1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_count", cycle_count, 0);
    check("rst_flags", flags, 0);
    check("rst_fail_code", fail_code, 0);
    rst = 1'b0;

    for (int h = 0; h < RSTC; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_core_rst_n", core_rst_n, (h == RSTC - 1) ? 1 : 0);
      check("hold_count", cycle_count, 0);
      check("hold_flags", flags, 0);
    end

    for (int j = 0; j < N; j++) begin
      check("run_count", cycle_count, (j <= k) ? j : k + 1);
      check("run_flags", flags, (j <= k) ? 5'b0 : ef);
      check("run_fail_code", fail_code, (j <= k) ? 32'd0 : code);
      check("run_core_rst_n", core_rst_n, 1);
      if (j == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("async_core_rst_n", core_rst_n, 0);
        check("async_count", cycle_count, 0);
        check("async_flags", flags, 0);
        return;
      end
      pc = pcv[j+1]; mem_we = wev[j]; mem_addr = addrv[j]; mem_wdata = datav[j];
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    for (int m = 0; m <= 5; m++) run_episode(m, -1);
    run_episode(2, 30);
    run_episode(0, -1);
    for (int e = 0; e < 16; e++) run_episode(6, -1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sim_run_controller.md
Name: sim_run_controller

Overview:
- Synthesizable run/verdict controller placed between the bench and the single-cycle core top.
- Replaces fixed-delay reset and fixed-time finish with:
  - a parametrised core-reset sequencer,
  - a cycle counter,
  - a tohost-style pass/fail monitor on data-memory stores,
  - a PC-stall halt detector,
  - a timeout watchdog.
- Exposes sticky verdict flags that the bench polls before ending simulation.

Parameters:
- DW, 32, data width of the store-data bus.
- AW, 32, width of the store-address and PC buses.
- CW, 32, width of the cycle counter.
- RST_CYCLES, 2, number of clk edges core_rst_n is held low after rst deasserts; legal range ≥1.
- MAX_CYCLES, 1000, RUN cycles allowed before timeout; 0 disables the watchdog.
- STALL_LIMIT, 8, consecutive unchanged-PC cycles that count as a halt; 0 disables stall detection.
- TOHOST_ADDR, 32'h0000_00FC, store address monitored for the verdict.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- pc  in  AW  core program counter.
- mem_we  in  1  core data-memory write enable.
- mem_addr  in  AW  core data-memory address.
- mem_wdata  in  DW  core data-memory write data.
- core_rst_n  out  1  active-low reset to the core.
- cycle_count  out  CW  RUN cycles elapsed.
- done  out  1  any terminal state reached.
- pass  out  1  tohost write of 1 received.
- fail  out  1  tohost write of a value other than 1 received.
- timeout  out  1  watchdog expired.
- halted  out  1  PC stall detected.
- fail_code  out  DW  mem_wdata >> 1 captured on fail.

Behaviour:
- States: HOLD, RUN, PASS, FAIL, TIMEOUT, HALT.
- Reset (rst=1, asynchronous, any state, including mid-run):
  - state=HOLD, core_rst_n=0, cycle_count=0, fail_code=0.
  - All flags = 0.
  - Hold counter, stall counter and prev_pc = 0.
- HOLD:
  - Hold counter increments each edge.
  - On the edge where the counter reaches RST_CYCLES-1: core_rst_n←1, state←RUN, prev_pc←pc.
  - core_rst_n is therefore low for exactly RST_CYCLES edges after rst falls.
  - mem_we and pc are ignored in HOLD.
- RUN, each edge:
  - cycle_count increments by 1, saturating at all-ones.
  - Exits are evaluated in this priority order:
    1. mem_we=1 and mem_addr==TOHOST_ADDR: if mem_wdata==1, go to PASS; otherwise go to FAIL and capture fail_code=mem_wdata>>1.
    2. MAX_CYCLES≠0 and cycle_count==MAX_CYCLES-1: go to TIMEOUT.
    3. STALL_LIMIT≠0 and pc==prev_pc and stall counter==STALL_LIMIT-1: go to HALT.
  - Stall counter: increments when pc==prev_pc; clears to 0 when pc≠prev_pc. prev_pc←pc every RUN edge.
  - Stores to any address other than TOHOST_ADDR have no effect.
- Terminal states (PASS, FAIL, TIMEOUT, HALT):
  - Sticky until rst.
  - cycle_count freezes at the value reached on the exit edge (counted, not incremented afterwards).
  - core_rst_n stays 1.
  - Further tohost writes are ignored; the first verdict wins.
- Flag outputs are registered and decoded from state:
  - done=1 in every terminal state.
  - Exactly one of pass/fail/timeout/halted is 1 in a terminal state; all are 0 in HOLD and RUN.
  - Flags are visible in the cycle after the exit edge.
- Simultaneous events:
  - tohost write and timeout on the same edge: tohost write wins.
  - Timeout and stall on the same edge: TIMEOUT wins.
- cycle_count wrap: it saturates and never wraps. With CW too small for MAX_CYCLES the watchdog never fires; this is a documented user error with no hardware check.

Test Plan:
- Reset sequence: rst high 2 cycles, then low, RST_CYCLES=3 → core_rst_n low for exactly 3 edges after rst falls, then 1; cycle_count=0 at RUN entry.
- Pass: in RUN cycle 10, drive mem_we=1, mem_addr=0xFC, mem_wdata=1 → next cycle done=1, pass=1, all other flags 0; cycle_count stays 11 for 20 more cycles.
- Fail with code: store 0xFC ← 0x0000_000B → fail=1, fail_code=5; a later store of 1 to 0xFC leaves pass=0.
- Timeout with priority: MAX_CYCLES=50, PC toggling, no stores → timeout=1 after cycle_count reaches 50. Repeat with a tohost write of 1 on cycle 49 → pass=1, timeout=0.
- Stall halt: STALL_LIMIT=8, PC incrementing by 4 then held at 0x40 → halted=1 after 8 unchanged cycles. Variant where PC changes at 7 unchanged cycles → no halt.
- Async reset mid-run: assert rst between clock edges during RUN at cycle 30 → core_rst_n=0, cycle_count=0, all flags 0 immediately without waiting for a clock edge; the full HOLD sequence repeats after rst deasserts.
